// File: rtl/tlm_pkg.sv
// tlm_pkg: shared definitions for the telemetry MMIO controller.
// Holds the register map offsets, CTRL/STATUS bit positions and the
// slave FSM state type used by tlm_mmio_ctrl.
package tlm_pkg;

  // Register map (byte offsets inside the slave window)
  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_SMC_LO  = 8'h08;
  localparam logic [7:0] OFF_SMC_HI  = 8'h0C;
  localparam logic [7:0] OFF_SMI_LO  = 8'h10;
  localparam logic [7:0] OFF_SMI_HI  = 8'h14;
  localparam logic [7:0] OFF_SST_LO  = 8'h18;
  localparam logic [7:0] OFF_SST_HI  = 8'h1C;
  localparam logic [7:0] OFF_CMP_LO  = 8'h20;
  localparam logic [7:0] OFF_CMP_HI  = 8'h24;
  localparam logic [7:0] OFF_SEQ     = 8'h28;

  // CTRL bit positions
  localparam int CTRL_EN        = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_CLEAR     = 2;
  localparam int CTRL_SNAP      = 3;
  localparam int CTRL_AUTO_SNAP = 4;

  // STATUS bit positions
  localparam int STAT_SNAP_VALID = 0;
  localparam int STAT_IRQ_PEND   = 1;

  // Slave handshake states
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

endpackage

// File: rtl/tlm_counter64.sv
// tlm_counter64: 64-bit event counter with enable and clear.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   inc_i         : event to count this cycle
//   en_i          : counting enabled
//   clr_i         : zero the counter (wins over an increment)
//   count_o       : registered counter value
// The counter wraps from all-ones to zero silently.
module tlm_counter64
  import tlm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        en_i,
  input  logic        clr_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && inc_i) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tlm_mmio_ctrl.sv
// tlm_mmio_ctrl: telemetry controller behind the data-port MMIO mux.
// Owns the mcycle/minstret/stall counters, snapshots them atomically into
// shadow registers, and raises a level interrupt when mcycle hits CMP.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   mem_addr_i             : byte offset in the window (bits [1:0] ignored)
//   mem_data_wr_i          : write data
//   mem_rd_i / mem_wr_i    : read request / byte write strobes
//   mem_accept_o           : request accepted this cycle
//   mem_ack_o              : response valid (one cycle after acceptance)
//   mem_data_rd_o          : read data, valid with mem_ack_o
//   retire_i / stall_i     : per-cycle retire and stall events
//   irq_o                  : compare interrupt (IRQ_PEND && IRQ_EN), registered
//   tlm_*_o                : live counter values
module tlm_mmio_ctrl
  import tlm_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_data_wr_i,
  input  logic              mem_rd_i,
  input  logic [3:0]        mem_wr_i,
  output logic              mem_accept_o,
  output logic              mem_ack_o,
  output logic [31:0]       mem_data_rd_o,
  input  logic              retire_i,
  input  logic              stall_i,
  output logic              irq_o,
  output logic [63:0]       tlm_mcycle_o,
  output logic [63:0]       tlm_minstret_o,
  output logic [63:0]       tlm_stall_o
);

  state_e state_q, state_d;

  logic        ctrlEn_q, ctrlIrqEn_q, ctrlAutoSnap_q;
  logic        ctrlIrqEn_d;
  logic        snapValid_q;
  logic        irqPend_q, irqPend_d;
  logic        irq_q;
  logic [31:0] snapSeq_q;
  logic [31:0] rdData_q;
  logic [63:0] shMcycle_q, shMinstret_q, shStall_q;
  logic [63:0] cmp_q;

  logic [63:0] mcycle, minstret, stallCnt;

  logic [ADDR_W-1:0] wordAddr;
  logic        reqValid, isWrite;
  logic        rdAccepted, wrAccepted;
  logic        ctrlWr, statusWr, cmpLoWr, cmpHiWr;
  logic        clearPulse, snapPulse, autoSnap, capture;
  logic        cmpMatch;
  logic [31:0] rdMux;

  // All bits of the offset participate; the low two are masked off here.
  assign wordAddr = mem_addr_i & ~ADDR_W'(3);

  // A request carrying any write strobe is a write, even with mem_rd_i set.
  assign reqValid   = mem_rd_i || (|mem_wr_i);
  assign isWrite    = |mem_wr_i;
  assign rdAccepted = mem_accept_o && mem_rd_i && !isWrite;
  assign wrAccepted = mem_accept_o && isWrite;

  // CTRL and STATUS fields live in byte lane 0.
  assign ctrlWr   = wrAccepted && (wordAddr == ADDR_W'(OFF_CTRL))   && mem_wr_i[0];
  assign statusWr = wrAccepted && (wordAddr == ADDR_W'(OFF_STATUS)) && mem_wr_i[0];
  assign cmpLoWr  = wrAccepted && (wordAddr == ADDR_W'(OFF_CMP_LO));
  assign cmpHiWr  = wrAccepted && (wordAddr == ADDR_W'(OFF_CMP_HI));

  assign clearPulse = ctrlWr && mem_data_wr_i[CTRL_CLEAR];
  assign snapPulse  = ctrlWr && mem_data_wr_i[CTRL_SNAP];
  assign autoSnap   = rdAccepted && ctrlAutoSnap_q && (wordAddr == ADDR_W'(OFF_SMC_LO));
  assign capture    = snapPulse || autoSnap;

  assign cmpMatch    = ctrlEn_q && (mcycle == cmp_q);
  assign ctrlIrqEn_d = ctrlWr ? mem_data_wr_i[CTRL_IRQ_EN] : ctrlIrqEn_q;

  tlm_counter64 uMcycle (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (1'b1),
    .en_i   (ctrlEn_q),
    .clr_i  (clearPulse),
    .count_o(mcycle)
  );

  tlm_counter64 uMinstret (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (retire_i),
    .en_i   (ctrlEn_q),
    .clr_i  (clearPulse),
    .count_o(minstret)
  );

  tlm_counter64 uStall (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (stall_i),
    .en_i   (ctrlEn_q),
    .clr_i  (clearPulse),
    .count_o(stallCnt)
  );

  // A fresh match wins over a same-cycle W1C so no event is lost.
  always_comb begin
    irqPend_d = irqPend_q;
    if (statusWr && mem_data_wr_i[STAT_IRQ_PEND]) begin
      irqPend_d = 1'b0;
    end
    if (cmpMatch) begin
      irqPend_d = 1'b1;
    end
  end

  // An auto-snap read returns the value being captured on this same edge,
  // i.e. the live registered mcycle rather than the old shadow.
  always_comb begin
    rdMux = '0;
    case (wordAddr)
      ADDR_W'(OFF_CTRL): begin
        rdMux[CTRL_EN]        = ctrlEn_q;
        rdMux[CTRL_IRQ_EN]    = ctrlIrqEn_q;
        rdMux[CTRL_AUTO_SNAP] = ctrlAutoSnap_q;
      end
      ADDR_W'(OFF_STATUS): begin
        rdMux[STAT_SNAP_VALID] = snapValid_q;
        rdMux[STAT_IRQ_PEND]   = irqPend_q;
      end
      ADDR_W'(OFF_SMC_LO): rdMux = ctrlAutoSnap_q ? mcycle[31:0] : shMcycle_q[31:0];
      ADDR_W'(OFF_SMC_HI): rdMux = shMcycle_q[63:32];
      ADDR_W'(OFF_SMI_LO): rdMux = shMinstret_q[31:0];
      ADDR_W'(OFF_SMI_HI): rdMux = shMinstret_q[63:32];
      ADDR_W'(OFF_SST_LO): rdMux = shStall_q[31:0];
      ADDR_W'(OFF_SST_HI): rdMux = shStall_q[63:32];
      ADDR_W'(OFF_CMP_LO): rdMux = cmp_q[31:0];
      ADDR_W'(OFF_CMP_HI): rdMux = cmp_q[63:32];
      ADDR_W'(OFF_SEQ):    rdMux = snapSeq_q;
      default:             rdMux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accept is forced low during reset so nothing is taken while in reset.
  always_comb begin
    state_d      = state_q;
    mem_accept_o = 1'b0;
    mem_ack_o    = 1'b0;
    case (state_q)
      IDLE: begin
        mem_accept_o = rst_ni;
        if (rst_ni && reqValid) begin
          state_d = ACK;
        end
      end
      ACK: begin
        mem_ack_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadows take the registered (pre-increment, pre-clear) counter values,
  // which is what makes SNAP|CLEAR capture the old values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrlEn_q       <= 1'b1;
      ctrlIrqEn_q    <= 1'b0;
      ctrlAutoSnap_q <= 1'b0;
      snapValid_q    <= 1'b0;
      irqPend_q      <= 1'b0;
      irq_q          <= 1'b0;
      snapSeq_q      <= '0;
      rdData_q       <= '0;
      shMcycle_q     <= '0;
      shMinstret_q   <= '0;
      shStall_q      <= '0;
      cmp_q          <= CMP_RST;
    end else begin
      if (ctrlWr) begin
        ctrlEn_q       <= mem_data_wr_i[CTRL_EN];
        ctrlIrqEn_q    <= mem_data_wr_i[CTRL_IRQ_EN];
        ctrlAutoSnap_q <= mem_data_wr_i[CTRL_AUTO_SNAP];
      end
      if (capture) begin
        shMcycle_q   <= mcycle;
        shMinstret_q <= minstret;
        shStall_q    <= stallCnt;
        snapSeq_q    <= snapSeq_q + 32'd1;
      end
      if (clearPulse) begin
        snapValid_q <= 1'b0;
      end else if (capture) begin
        snapValid_q <= 1'b1;
      end
      irqPend_q <= irqPend_d;
      irq_q     <= irqPend_d && ctrlIrqEn_d;
      for (int b = 0; b < 4; b++) begin
        if (cmpLoWr && mem_wr_i[b]) begin
          cmp_q[8*b +: 8] <= mem_data_wr_i[8*b +: 8];
        end
        if (cmpHiWr && mem_wr_i[b]) begin
          cmp_q[32 + 8*b +: 8] <= mem_data_wr_i[8*b +: 8];
        end
      end
      if (rdAccepted) begin
        rdData_q <= rdMux;
      end else if (wrAccepted) begin
        rdData_q <= '0;
      end
    end
  end

  assign mem_data_rd_o  = rdData_q;
  assign irq_o          = irq_q;
  assign tlm_mcycle_o   = mcycle;
  assign tlm_minstret_o = minstret;
  assign tlm_stall_o    = stallCnt;

endmodule

// File: tb/tb_tlm_mmio_ctrl.sv
// tb_tlm_mmio_ctrl: bench for tlm_mmio_ctrl with a register-map level
// reference model, a per-cycle compare process, directed scenarios with
// literal expectations, and a randomized request phase.
module tb_tlm_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  memAddr;
  logic [31:0] memWrData;
  logic        memRd;
  logic [3:0]  memWr;
  logic        memAccept, memAck;
  logic [31:0] memRdData;
  logic        retire, stall;
  logic        irq;
  logic [63:0] tlmMcycle, tlmMinstret, tlmStall;

  always #5 clk = ~clk;

  tlm_mmio_ctrl #(
    .ADDR_W (8),
    .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .mem_addr_i    (memAddr),
    .mem_data_wr_i (memWrData),
    .mem_rd_i      (memRd),
    .mem_wr_i      (memWr),
    .mem_accept_o  (memAccept),
    .mem_ack_o     (memAck),
    .mem_data_rd_o (memRdData),
    .retire_i      (retire),
    .stall_i       (stall),
    .irq_o         (irq),
    .tlm_mcycle_o  (tlmMcycle),
    .tlm_minstret_o(tlmMinstret),
    .tlm_stall_o   (tlmStall)
  );

  int total = 0;
  int bad   = 0;
  bit checkOn = 1'b0;
  bit randomTraffic = 1'b0;

  // Reference model state: the architectural registers after each edge.
  logic [63:0] mMc = '0, mMi = '0, mSt = '0;
  logic [63:0] mShMc = '0, mShMi = '0, mShSt = '0;
  logic [63:0] mCmp = '1;
  logic        mEn = 1'b1, mIrqEn = 1'b0, mAuto = 1'b0;
  logic        mSnapValid = 1'b0, mIrqPend = 1'b0;
  logic        mBusy = 1'b0, mAckIsRead = 1'b0;
  logic [31:0] mSeq = '0, mAckData = '0;
  logic [63:0] acceptMc = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [7:0] a);
    case (a)
      8'h00:   return {27'd0, mAuto, 2'b00, mIrqEn, mEn};
      8'h04:   return {30'd0, mIrqPend, mSnapValid};
      8'h08:   return mAuto ? mMc[31:0] : mShMc[31:0];
      8'h0C:   return mShMc[63:32];
      8'h10:   return mShMi[31:0];
      8'h14:   return mShMi[63:32];
      8'h18:   return mShSt[31:0];
      8'h1C:   return mShSt[63:32];
      8'h20:   return mCmp[31:0];
      8'h24:   return mCmp[63:32];
      8'h28:   return mSeq;
      default: return 32'd0;
    endcase
  endfunction

  // Model: one step per clock edge from the inputs seen at that edge.
  always @(posedge clk) begin : model
    logic       isWr, fire, ctrlW, statW, clr, cap, match;
    logic [7:0] a;
    if (!rstN) begin
      mMc = '0; mMi = '0; mSt = '0;
      mShMc = '0; mShMi = '0; mShSt = '0;
      mCmp = 64'hFFFF_FFFF_FFFF_FFFF;
      mEn = 1'b1; mIrqEn = 1'b0; mAuto = 1'b0;
      mSnapValid = 1'b0; mIrqPend = 1'b0;
      mBusy = 1'b0; mAckIsRead = 1'b0;
      mSeq = '0; mAckData = '0;
    end else begin
      isWr  = (memWr != 4'd0);
      fire  = !mBusy && (isWr || memRd);
      a     = {memAddr[7:2], 2'b00};
      ctrlW = fire && isWr && (a == 8'h00) && memWr[0];
      statW = fire && isWr && (a == 8'h04) && memWr[0];
      clr   = ctrlW && memWrData[2];
      cap   = (ctrlW && memWrData[3]) || (fire && !isWr && (a == 8'h08) && mAuto);
      match = mEn && (mMc == mCmp);
      if (fire) begin
        mAckIsRead = !isWr;
        mAckData   = isWr ? 32'd0 : modelRead(a);
      end
      mBusy = fire;
      if (cap) begin
        mShMc = mMc; mShMi = mMi; mShSt = mSt;
        mSeq  = mSeq + 32'd1;
        mSnapValid = 1'b1;
      end
      if (clr) begin
        mMc = '0; mMi = '0; mSt = '0;
        mSnapValid = 1'b0;
      end else if (mEn) begin
        mMc = mMc + 64'd1;
        mMi = mMi + 64'(retire);
        mSt = mSt + 64'(stall);
      end
      if (match) mIrqPend = 1'b1;
      else if (statW && memWrData[1]) mIrqPend = 1'b0;
      if (ctrlW) begin
        mEn = memWrData[0]; mIrqEn = memWrData[1]; mAuto = memWrData[4];
      end
      for (int b = 0; b < 4; b++) begin
        if (fire && (a == 8'h20) && memWr[b]) mCmp[8*b +: 8] = memWrData[8*b +: 8];
        if (fire && (a == 8'h24) && memWr[b]) mCmp[32 + 8*b +: 8] = memWrData[8*b +: 8];
      end
    end
  end

  // Compare process: every cycle, mid-way between edges.
  always @(negedge clk) begin
    #1;
    if (checkOn) begin
      checkOutput("accept", memAccept, rstN && !mBusy);
      checkOutput("ack", memAck, mBusy);
      if (mBusy && mAckIsRead) checkOutput("rdata", memRdData, mAckData);
      checkOutput("irq", irq, mIrqPend && mIrqEn);
      checkOutput("mcycle", tlmMcycle, mMc);
      checkOutput("minstret", tlmMinstret, mMi);
      checkOutput("stall", tlmStall, mSt);
    end
  end

  task automatic tickNeg();
    @(negedge clk);
    if (randomTraffic) begin
      retire = 1'($urandom_range(0, 1));
      stall  = 1'($urandom_range(0, 1));
    end
  endtask

  // One complete request; returns at the ack cycle with the read data.
  task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data,
                               input logic rd, input logic [3:0] wr,
                               output logic [31:0] rdata);
    int guard = 0;
    memAddr = addr; memWrData = data; memRd = rd; memWr = wr;
    while (!memAccept && guard < 20) begin
      tickNeg();
      guard++;
    end
    if (guard >= 20) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout: got accept=%0b expected 1 within 20 cycles", memAccept);
    end
    acceptMc = mMc;
    tickNeg();
    memRd = 1'b0; memWr = 4'd0;
    checkOutput("req_ack", memAck, 1);
    rdata = memRdData;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd, lo, hi, data;
    logic [63:0] v0, v1, capN;
    logic [7:0]  a;
    logic [3:0]  strobe;
    int guard, sel, kind;

    rstN = 1'b0; memAddr = '0; memWrData = '0; memRd = 1'b0; memWr = '0;
    retire = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    checkOn = 1'b1;
    checkOutput("rst_ack", memAck, 0);
    checkOutput("rst_rdata", memRdData, 0);
    checkOutput("rst_irq", irq, 0);
    checkOutput("rst_mcycle", tlmMcycle, 0);
    checkOutput("rst_accept", memAccept, 0);
    rstN = 1'b1;
    #1 checkOutput("rel_accept", memAccept, 1);

    // 500 cycles, retire every fifth cycle
    for (int i = 0; i < 500; i++) begin
      retire = (i % 5 == 0);
      tickNeg();
    end
    retire = 1'b0;
    applyStimulus(8'h00, 32'h9, 1'b0, 4'hF, rd);
    applyStimulus(8'h08, 32'h0, 1'b1, 4'h0, rd);
    checkOutput("snap_mc_range", (rd >= 32'd498 && rd <= 32'd502), 1);
    checkOutput("snap_mc_lo", rd, 500);
    applyStimulus(8'h0C, 32'h0, 1'b1, 4'h0, rd); checkOutput("snap_mc_hi", rd, 0);
    applyStimulus(8'h10, 32'h0, 1'b1, 4'h0, rd); checkOutput("snap_mi_lo", rd, 100);
    applyStimulus(8'h14, 32'h0, 1'b1, 4'h0, rd); checkOutput("snap_mi_hi", rd, 0);
    applyStimulus(8'h18, 32'h0, 1'b1, 4'h0, rd); checkOutput("snap_st_lo", rd, 0);
    applyStimulus(8'h1C, 32'h0, 1'b1, 4'h0, rd); checkOutput("snap_st_hi", rd, 0);
    applyStimulus(8'h28, 32'h0, 1'b1, 4'h0, rd); checkOutput("snap_seq1", rd, 1);
    applyStimulus(8'h04, 32'h0, 1'b1, 4'h0, rd); checkOutput("status_valid", rd, 1);
    applyStimulus(8'h20, 32'h0, 1'b1, 4'h0, rd); checkOutput("cmp_lo_rst", rd, 32'hFFFF_FFFF);

    // Disable window
    applyStimulus(8'h00, 32'h0, 1'b0, 4'hF, rd);
    v0 = tlmMcycle;
    repeat (50) tickNeg();
    applyStimulus(8'h00, 32'h1, 1'b0, 4'hF, rd);
    v1 = tlmMcycle;
    checkOutput("en_window_delta", ((v1 - v0) <= 64'd3), 1);

    // AUTO_SNAP pair
    applyStimulus(8'h00, 32'h11, 1'b0, 4'hF, rd);
    applyStimulus(8'h08, 32'h0, 1'b1, 4'h0, lo);
    capN = acceptMc;
    applyStimulus(8'h0C, 32'h0, 1'b1, 4'h0, hi);
    checkOutput("auto_pair", {hi, lo}, capN);

    // Compare interrupt at mcycle 1000
    applyStimulus(8'h24, 32'h0, 1'b0, 4'hF, rd);
    applyStimulus(8'h20, 32'd1000, 1'b0, 4'hF, rd);
    applyStimulus(8'h00, 32'h7, 1'b0, 4'hF, rd);
    applyStimulus(8'h04, 32'h2, 1'b0, 4'hF, rd);
    guard = 0;
    while (tlmMcycle != 64'd1000 && guard < 2000) begin
      tickNeg();
      guard++;
    end
    checkOutput("cmp_reached", tlmMcycle, 1000);
    checkOutput("irq_before_match", irq, 0);
    tickNeg();
    checkOutput("irq_after_match", irq, 1);
    applyStimulus(8'h04, 32'h2, 1'b0, 4'hF, rd);
    checkOutput("irq_after_w1c", irq, 0);

    // SNAP|CLEAR together
    applyStimulus(8'h00, 32'hD, 1'b0, 4'hF, rd);
    capN = acceptMc;
    checkOutput("live_after_clear", tlmMcycle, 0);
    applyStimulus(8'h08, 32'h0, 1'b1, 4'h0, rd); checkOutput("clr_snap_lo", rd, capN[31:0]);
    applyStimulus(8'h0C, 32'h0, 1'b1, 4'h0, rd); checkOutput("clr_snap_hi", rd, capN[63:32]);
    applyStimulus(8'h04, 32'h0, 1'b1, 4'h0, rd); checkOutput("clr_status", rd, 0);
    applyStimulus(8'h28, 32'h0, 1'b1, 4'h0, rd); checkOutput("snap_seq3", rd, 3);

    // Back-to-back reads of an unmapped offset
    memAddr = 8'h3C; memRd = 1'b1;
    tickNeg();
    for (int k = 0; k < 4; k++) begin
      checkOutput("b2b_accept", memAccept, (k % 2 == 0));
      checkOutput("b2b_ack", memAck, (k % 2 == 1));
      if (k % 2 == 1) checkOutput("b2b_rdata", memRdData, 0);
      tickNeg();
    end
    memRd = 1'b0;

    // Randomized requests
    randomTraffic = 1'b1;
    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 3)) tickNeg();
      sel  = $urandom_range(0, 11);
      a    = (sel == 11) ? 8'h3C : 8'(sel * 4);
      a    = a | 8'($urandom_range(0, 3));
      kind = $urandom_range(0, 2);
      data = $urandom;
      strobe = (a < 8'h08) ? 4'hF : 4'($urandom_range(1, 15));
      if (a[7:2] == 6'd0) begin
        data = data & 32'h1F;
        if ($urandom_range(0, 3) != 0) data[0] = 1'b1;
        if ($urandom_range(0, 3) != 0) data[2] = 1'b0;
      end
      if (a[7:2] == 6'h08 && $urandom_range(0, 1) == 1) data = mMc[31:0] + $urandom_range(4, 30);
      if (a[7:2] == 6'h09 && $urandom_range(0, 3) != 0) data = mMc[63:32];
      applyStimulus(a, data, (kind != 1), (kind == 0) ? 4'h0 : strobe, rd);
    end
    randomTraffic = 1'b0;
    retire = 1'b0; stall = 1'b0;
    tickNeg();

    // Reset while an ack is being presented
    memAddr = 8'h00; memRd = 1'b1;
    guard = 0;
    while (!memAccept && guard < 20) begin
      tickNeg();
      guard++;
    end
    tickNeg();
    memRd = 1'b0;
    rstN = 1'b0;
    tickNeg();
    checkOutput("midrst_ack", memAck, 0);
    checkOutput("midrst_rdata", memRdData, 0);
    checkOutput("midrst_mcycle", tlmMcycle, 0);
    checkOutput("midrst_irq", irq, 0);
    tickNeg();
    rstN = 1'b1;
    tickNeg();
    applyStimulus(8'h00, 32'h0, 1'b1, 4'h0, rd); checkOutput("post_rst_ctrl", rd, 1);
    applyStimulus(8'h24, 32'h0, 1'b1, 4'h0, rd); checkOutput("post_rst_cmp_hi", rd, 32'hFFFF_FFFF);
    applyStimulus(8'h04, 32'h0, 1'b1, 4'h0, rd); checkOutput("post_rst_status", rd, 0);
    applyStimulus(8'h28, 32'h0, 1'b1, 4'h0, rd); checkOutput("post_rst_seq", rd, 0);
    applyStimulus(8'h08, 32'h0, 1'b1, 4'h0, rd); checkOutput("post_rst_shadow", rd, 0);
    tickNeg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
